// File: rtl/gate_vector_sequencer.sv
// Exhaustive truth-table sweeper for a small combinational gate cell.
// Steps through every input vector, waits a settle window, then samples and scores dut_y.
module gate_vector_sequencer #(
    parameter int                   N_IN   = 2,
    parameter int                   SETTLE = 2,
    parameter logic [2**N_IN-1:0]   TRUTH  = 4'b0001
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic [N_IN-1:0] stim,
    input  logic            dut_y,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] fail_vec
);

    localparam int              CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(SETTLE - 1);
    localparam logic [N_IN-1:0] LAST_VEC = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          mismatch;

    // Only consumed inside S_CHECK, so dut_y never reaches an output combinationally.
    assign mismatch = (dut_y != TRUTH[stim]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            stim      <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_vec  <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state     <= S_SETTLE;
                        stim      <= '0;
                        cnt       <= '0;
                        err_count <= '0;
                        fail_vec  <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                    end
                end

                S_SETTLE: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        state <= S_CHECK;
                    end
                end

                S_CHECK: begin
                    if (mismatch) begin
                        err_count <= err_count + 1'b1;
                        if (err_count == '0) begin
                            fail_vec <= stim;
                        end
                    end
                    // The last vector holds stim so the increment never wraps it.
                    if (stim == LAST_VEC) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_count == '0) && !mismatch;
                    end else begin
                        stim  <= stim + 1'b1;
                        cnt   <= '0;
                        state <= S_SETTLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
